// File: rtl/tiff_stream_writer.sv
// tiff_stream_writer: serializes one grayscale frame into a big-endian ("MM")
// uncompressed TIFF byte stream: 8-byte header, pixel rows, 10-entry IFD.
// Optional macro TIFF_STREAM_ROW_DBUF_EN selects two ping-pong row buffers;
// without it a single row buffer is used and each row boundary costs one bubble.
module tiff_stream_writer #(
    parameter int ROWS       = 256,
    parameter int COLUMNS    = 256,
    parameter int PIXEL_BITS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [PIXEL_BITS*COLUMNS-1:0] row_data,
    input  logic                          row_valid,
    output logic                          row_ready,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int BPP       = PIXEL_BITS / 8;
    localparam int ROW_BYTES = COLUMNS * BPP;
    localparam int ROW_W     = PIXEL_BITS * COLUMNS;
    localparam int IDX_W     = $clog2((ROW_BYTES > 126) ? ROW_BYTES : 126);
    localparam int ROW_CNT_W = $clog2(ROWS + 1);

`ifdef TIFF_STREAM_ROW_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    localparam logic [31:0] IMG_BYTES  = 32'(ROWS * COLUMNS * BPP);
    localparam logic [31:0] IFD_OFFSET = IMG_BYTES + 32'd8;
    localparam logic [63:0] HDR_BLOB   = {32'h4D4D_002A, IFD_OFFSET};
    localparam logic [15:0] T_SHORT    = 16'd3;
    localparam logic [15:0] T_LONG     = 16'd4;

    // Trailer image: entry count, ten 12-byte entries, next-IFD offset.
    localparam logic [1007:0] IFD_BLOB = {
        16'd10,
        16'h00FE, T_LONG,  32'd1, 32'd0,
        16'h0100, T_SHORT, 32'd1, 16'(COLUMNS),    16'd0,
        16'h0101, T_SHORT, 32'd1, 16'(ROWS),       16'd0,
        16'h0102, T_SHORT, 32'd1, 16'(PIXEL_BITS), 16'd0,
        16'h0103, T_SHORT, 32'd1, 16'd1,           16'd0,
        16'h0106, T_SHORT, 32'd1, 16'd1,           16'd0,
        16'h0111, T_LONG,  32'd1, 32'd8,
        16'h0115, T_SHORT, 32'd1, 16'd1,           16'd0,
        16'h0117, T_LONG,  32'd1, IMG_BYTES,
        16'h011C, T_SHORT, 32'd1, 16'd1,           16'd0,
        32'd0
    };

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX, S_IFD, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ROW_CNT_W-1:0]   rows_in_q, rows_in_d;
    logic [ROW_CNT_W-1:0]   rows_out_q, rows_out_d;
    logic [ROW_W-1:0]       buf_q [2];
    logic [ROW_W-1:0]       buf_d [2];
    logic [1:0]             full_q, full_d;
    logic                   rd_sel_q, rd_sel_d;
    logic                   wr_sel_q, wr_sel_d;
    logic                   drain_q, drain_d;
    logic [7:0]             byte_data_q, byte_data_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   can_load, row_accept, have_byte;
    logic [ROW_W-1:0]       pix_src;

    // Byte k of a row; 16-bit pixels go out MSB first (swap within each pair).
    function automatic logic [7:0] row_byte(input logic [ROW_W-1:0] row,
                                            input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] kk;
        kk = k ^ IDX_W'(BPP - 1);
        return 8'(row >> {kk, 3'b000});
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [2:0] i);
        return 8'(HDR_BLOB >> {3'd7 - i, 3'b000});
    endfunction

    function automatic logic [7:0] ifd_byte(input logic [IDX_W-1:0] i);
        return 8'(IFD_BLOB >> {IDX_W'(125) - i, 3'b000});
    endfunction

    assign can_load   = !byte_valid_q || byte_ready;
    assign row_ready  = (state_q == S_PIX) && !full_q[wr_sel_q] &&
                        (rows_in_q != ROW_CNT_W'(ROWS)) && (DBUF || !drain_q);
    assign row_accept = row_valid && row_ready;
    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Next-state logic: walks header, rows, trailer and feeds the output register.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rows_in_d    = rows_in_q;
        rows_out_d   = rows_out_q;
        buf_d        = buf_q;
        full_d       = full_q;
        rd_sel_d     = rd_sel_q;
        wr_sel_d     = wr_sel_q;
        drain_d      = 1'b0;
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q && !byte_ready;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        have_byte    = 1'b0;
        pix_src      = '0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d      = S_HDR;
                    byte_data_d  = hdr_byte(3'd0);
                    byte_valid_d = 1'b1;
                    idx_d        = IDX_W'(1);
                    busy_d       = 1'b1;
                    rows_in_d    = '0;
                    rows_out_d   = '0;
                    full_d       = '0;
                    rd_sel_d     = 1'b0;
                    wr_sel_d     = 1'b0;
                end
            end
            S_HDR: begin
                if (can_load) begin
                    byte_data_d  = hdr_byte(idx_q[2:0]);
                    byte_valid_d = 1'b1;
                    if (idx_q == IDX_W'(7)) begin
                        state_d = S_PIX;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PIX: begin
                if (row_accept) begin
                    buf_d[wr_sel_q]  = row_data;
                    full_d[wr_sel_q] = 1'b1;
                    wr_sel_d         = DBUF ? ~wr_sel_q : 1'b0;
                    rows_in_d        = rows_in_q + ROW_CNT_W'(1);
                end
                if (full_q[rd_sel_q]) begin
                    have_byte = 1'b1;
                    pix_src   = buf_q[rd_sel_q];
                end else if (row_accept) begin
                    have_byte = 1'b1;
                    pix_src   = row_data;
                end
                if (can_load && have_byte) begin
                    byte_data_d  = row_byte(pix_src, idx_q);
                    byte_valid_d = 1'b1;
                    if (idx_q == IDX_W'(ROW_BYTES - 1)) begin
                        idx_d            = '0;
                        full_d[rd_sel_q] = 1'b0;
                        rd_sel_d         = DBUF ? ~rd_sel_q : 1'b0;
                        drain_d          = 1'b1;
                        rows_out_d       = rows_out_q + ROW_CNT_W'(1);
                        if (rows_out_q == ROW_CNT_W'(ROWS - 1)) begin
                            state_d = S_IFD;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_IFD: begin
                if (idx_q != IDX_W'(126)) begin
                    if (can_load) begin
                        byte_data_d  = ifd_byte(idx_q);
                        byte_valid_d = 1'b1;
                        idx_d        = idx_q + IDX_W'(1);
                    end
                end else if (byte_valid_q && byte_ready) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and registered outputs, synchronously cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rows_in_q    <= '0;
            rows_out_q   <= '0;
            full_q       <= '0;
            rd_sel_q     <= 1'b0;
            wr_sel_q     <= 1'b0;
            drain_q      <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rows_in_q    <= rows_in_d;
            rows_out_q   <= rows_out_d;
            full_q       <= full_d;
            rd_sel_q     <= rd_sel_d;
            wr_sel_q     <= wr_sel_d;
            drain_q      <= drain_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Row buffer contents; validity lives in full_q so the data needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_tiff_stream_writer.sv
// tb_tiff_stream_writer: drives 4x4 frames into 8-bit and 16-bit writers and
// compares every consumed byte with a TIFF file assembled from first principles.
module tb_tiff_stream_writer;

    localparam int R = 4;
    localparam int C = 4;

`ifdef TIFF_STREAM_ROW_DBUF_EN
    localparam int EXP_GAPS = 0;
`else
    localparam int EXP_GAPS = R - 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              row_valid;
    logic              byte_ready;
    logic              sel16;
    logic [C*8-1:0]    row_data8;
    logic [C*16-1:0]   row_data16;
    logic              rr8, bv8, busy8, fd8;
    logic              rr16, bv16, busy16, fd16;
    logic [7:0]        bd8, bd16;
    logic              o_rr, o_bv, o_busy, o_fd;
    logic [7:0]        o_bd;

    int                checks = 0;
    int                errors = 0;
    int                pix [R][C];
    logic [7:0]        expQ [$];

    // Free-running clock for both writers.
    always #5 clk = ~clk;

    tiff_stream_writer #(.ROWS(R), .COLUMNS(C), .PIXEL_BITS(8)) dut8 (
        .clk(clk), .reset(reset), .frame_start(frame_start && !sel16),
        .row_data(row_data8), .row_valid(row_valid && !sel16), .row_ready(rr8),
        .byte_data(bd8), .byte_valid(bv8), .byte_ready(byte_ready),
        .busy(busy8), .frame_done(fd8)
    );

    tiff_stream_writer #(.ROWS(R), .COLUMNS(C), .PIXEL_BITS(16)) dut16 (
        .clk(clk), .reset(reset), .frame_start(frame_start && sel16),
        .row_data(row_data16), .row_valid(row_valid && sel16), .row_ready(rr16),
        .byte_data(bd16), .byte_valid(bv16), .byte_ready(byte_ready),
        .busy(busy16), .frame_done(fd16)
    );

    assign o_rr   = sel16 ? rr16   : rr8;
    assign o_bv   = sel16 ? bv16   : bv8;
    assign o_bd   = sel16 ? bd16   : bd8;
    assign o_busy = sel16 ? busy16 : busy8;
    assign o_fd   = sel16 ? fd16   : fd8;

    task automatic checkOutput(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pushBE(input longint v, input int n);
        for (int i = n - 1; i >= 0; i--) expQ.push_back(8'((v >> (8 * i)) & 255));
    endtask

    // Reference TIFF file: header, pixels row-major (MSB first), then the IFD.
    task automatic buildExpected(input bit is16);
        int bpp;
        int img;
        int tags [10] = '{'h00FE, 'h0100, 'h0101, 'h0102, 'h0103,
                          'h0106, 'h0111, 'h0115, 'h0117, 'h011C};
        int typs [10] = '{4, 3, 3, 3, 3, 3, 4, 3, 4, 3};
        int vals [10];
        bpp = is16 ? 2 : 1;
        img = R * C * bpp;
        vals = '{0, C, R, 8 * bpp, 1, 1, 8, 1, img, 1};
        expQ.delete();
        pushBE(32'h4D4D002A, 4);
        pushBE(img + 8, 4);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                pushBE(pix[r][c], bpp);
        pushBE(10, 2);
        for (int i = 0; i < 10; i++) begin
            pushBE(tags[i], 2);
            pushBE(typs[i], 2);
            pushBE(1, 4);
            if (typs[i] == 3) begin
                pushBE(vals[i], 2);
                pushBE(0, 2);
            end else begin
                pushBE(vals[i], 4);
            end
        end
        pushBE(0, 4);
    endtask

    function automatic logic [C*16-1:0] rowVec(input int r, input bit is16);
        logic [C*16-1:0] v;
        v = '0;
        for (int c = 0; c < C; c++) begin
            if (is16) v[c*16 +: 16] = 16'(pix[r][c]);
            else      v[c*8 +: 8]   = 8'(pix[r][c]);
        end
        return v;
    endfunction

    // Runs one frame: offers rows eagerly, randomizes byte_ready, checks stream.
    task automatic applyStimulus(input bit is16, input int readyPct, input bit fsMid,
                                 input int abortRow, input bit checkGaps, input string name);
        int n = 0, rowIdx = 0, cycle = 0, lastConsume = -10;
        int gaps = 0, gapCycles = 0, rrEarly = 0;
        bit started = 0, prevValid = 0, prevStall = 0, doneSeen = 0;
        bit finished = 0, fsPulsed = 0, firstAccept = 0;
        logic [7:0] prevData = 8'h00;
        logic [C*16-1:0] rv;
        buildExpected(is16);
        sel16 = is16;
        rv = rowVec(0, is16);
        row_data8 = rv[C*8-1:0];
        row_data16 = rv;
        row_valid = 1'b1;
        byte_ready = 1'b1;
        frame_start = 1'b1;
        checkOutput({name, "_idle_row_ready"}, o_rr, 0);
        @(negedge clk);
        frame_start = 1'b0;
        checkOutput({name, "_start_valid"}, o_bv, 1);
        checkOutput({name, "_start_byte"}, o_bd, 8'h4D);
        checkOutput({name, "_start_busy"}, o_busy, 1);
        while (!finished && cycle < 2000) begin
            if (abortRow >= 0 && rowIdx == abortRow) begin
                reset = 1'b1;
                @(negedge clk);
                checkOutput({name, "_rst_valid"}, o_bv, 0);
                checkOutput({name, "_rst_data"}, o_bd, 0);
                checkOutput({name, "_rst_busy"}, o_busy, 0);
                checkOutput({name, "_rst_row_ready"}, o_rr, 0);
                checkOutput({name, "_rst_done"}, o_fd, 0);
                reset = 1'b0;
                row_valid = 1'b0;
                return;
            end
            if (doneSeen) begin
                checkOutput({name, "_post_busy"}, o_busy, 0);
                checkOutput({name, "_post_done"}, o_fd, 0);
                finished = 1;
                break;
            end
            if (o_fd) begin
                doneSeen = 1;
                checkOutput({name, "_done_timing"}, cycle, lastConsume + 1);
                checkOutput({name, "_done_busy"}, o_busy, 1);
                checkOutput({name, "_done_bytes"}, n, expQ.size());
            end
            if (prevStall) begin
                checkOutput({name, "_stall_valid"}, o_bv, 1);
                checkOutput({name, "_stall_data"}, o_bd, prevData);
            end
            if (o_bv) started = 1;
            else if (started && n < expQ.size()) begin
                gapCycles++;
                if (prevValid) gaps++;
            end
            if (o_rr && (n + int'(o_bv)) < 8) rrEarly++;
            byte_ready = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
            frame_start = fsMid && !fsPulsed && rowIdx == 2;
            if (frame_start) fsPulsed = 1;
            row_valid = rowIdx < R;
            if (rowIdx < R) begin
                rv = rowVec(rowIdx, is16);
                row_data8 = rv[C*8-1:0];
                row_data16 = rv;
            end
            if (row_valid && o_rr) begin
                if (!firstAccept) begin
                    firstAccept = 1;
                    checkOutput({name, "_first_row_after_hdr"}, n + int'(o_bv), 8);
                end
                rowIdx++;
            end
            if (o_bv && byte_ready) begin
                if (n < expQ.size())
                    checkOutput($sformatf("%s_byte%0d", name, n), o_bd, expQ[n]);
                else
                    checkOutput({name, "_extra_byte"}, n, expQ.size() - 1);
                lastConsume = cycle;
                n++;
            end
            prevStall = o_bv && !byte_ready;
            prevData = o_bd;
            prevValid = o_bv;
            @(negedge clk);
            cycle++;
        end
        frame_start = 1'b0;
        row_valid = 1'b0;
        checkOutput({name, "_completed"}, finished, 1);
        checkOutput({name, "_total_bytes"}, n, expQ.size());
        checkOutput({name, "_early_row_ready"}, rrEarly, 0);
        if (checkGaps) begin
            checkOutput({name, "_gaps"}, gaps, EXP_GAPS);
            checkOutput({name, "_gap_cycles"}, gapCycles, EXP_GAPS);
        end
    endtask

    // Directed sequence of frames covering the main and corner behaviours.
    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        row_valid = 1'b0;
        byte_ready = 1'b1;
        sel16 = 1'b0;
        row_data8 = '0;
        row_data16 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", bv8, 0);
        checkOutput("reset_data", bd8, 0);
        checkOutput("reset_row_ready", rr8, 0);
        checkOutput("reset_busy", busy8, 0);
        checkOutput("reset_done", fd8, 0);
        checkOutput("reset_valid16", bv16, 0);
        reset = 1'b0;
        row_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_row_ready", rr8, 0);
            checkOutput("idle_busy", busy8, 0);
        end
        row_valid = 1'b0;

        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) pix[r][c] = 16 * r + c;
        applyStimulus(0, 100, 0, -1, 1, "t1");

        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) pix[r][c] = $urandom_range(0, 255);
        applyStimulus(0, 50, 1, -1, 0, "rand8");

        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) pix[r][c] = 16 * r + c;
        applyStimulus(0, 50, 0, -1, 0, "t1stall");
        applyStimulus(0, 100, 0, 2, 0, "abort");
        applyStimulus(0, 100, 0, -1, 1, "t1after");

        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) pix[r][c] = 'hABCD;
        applyStimulus(1, 100, 0, -1, 1, "abcd16");

        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) pix[r][c] = $urandom_range(0, 65535);
        applyStimulus(1, 50, 1, -1, 0, "rand16");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
